// File: rtl/lib_switch_allocator_rr_pkg.sv
// lib_switch_allocator_rr_pkg: shared sizing defaults and pointer-width helper
package lib_switch_allocator_rr_pkg;
  localparam int N_DEF = 5;
  localparam int M_DEF = 5;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lib_switch_allocator_rr_arbiter.sv
// lib_arbiter_rr: single N-input round-robin arbiter with its own priority pointer
module lib_arbiter_rr
  import lib_switch_allocator_rr_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:N-1] i_request,
  input  logic         i_en,
  output logic [0:N-1] o_grant
);
  localparam int W = ptr_w(N);
  logic [W-1:0] ptr_q, ptr_d, win, idx;
  logic         found;
  always_comb begin
    o_grant = '0;
    found = 1'b0;
    win = ptr_q;
    idx = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = W'((int'(ptr_q) + k) % N);
      if (!found && !reset && i_en && i_request[idx]) begin
        o_grant[idx] = 1'b1;
        found = 1'b1;
        win = idx;
      end
    end
    ptr_d = !found ? ptr_q : (win == W'(N - 1)) ? '0 : win + W'(1);
  end
  always_ff @(posedge clk) begin
    ptr_q <= reset ? '0 : ptr_d;
  end
endmodule

// File: rtl/lib_switch_allocator_rr.sv
// lib_switch_allocator_rr: NxM round-robin switch allocator driving one-hot crossbar selects
module lib_switch_allocator_rr
  import lib_switch_allocator_rr_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:N-1][0:M-1]  i_request,
  input  logic [0:M-1]         i_en,
  output logic [0:M-1][0:N-1]  o_sel,
  output logic [0:N-1]         o_grant
);
  logic [0:N-1][0:M-1] req_s;
  logic [0:M-1][0:N-1] cand;
  always_comb begin
    req_s = '0;
    cand = '0;
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) begin
        if (i_request[n][m] && !(|req_s[n])) req_s[n][m] = 1'b1;
      end
    end
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) cand[m][n] = req_s[n][m];
    end
  end
  for (genvar g = 0; g < M; g++) begin : g_arb
    lib_arbiter_rr #(.N(N)) u_arb (
      .clk      (clk),
      .reset    (reset),
      .i_request(cand[g]),
      .i_en     (i_en[g]),
      .o_grant  (o_sel[g])
    );
  end
  always_comb begin
    o_grant = '0;
    for (int m = 0; m < M; m++) o_grant = o_grant | o_sel[m];
  end
endmodule

// File: tb/tb_lib_switch_allocator_rr.sv
// tb_lib_switch_allocator_rr: directed and random checks against a behavioural allocator model
module tb_lib_switch_allocator_rr;
  localparam int N = 5;
  localparam int M = 5;
  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [0:N-1][0:M-1] i_request = '0;
  logic [0:M-1]        i_en = '0;
  logic [0:M-1][0:N-1] o_sel;
  logic [0:N-1]        o_grant;
  logic [7:0]          pkt [N];
  int                  mptr [M];
  int                  vectors = 0;
  int                  miscompares = 0;
  always #5 clk = ~clk;
  lib_switch_allocator_rr #(.N(N), .M(M)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_request(i_request),
    .i_en     (i_en),
    .o_sel    (o_sel),
    .o_grant  (o_grant)
  );
  function automatic logic [0:M-1] oh(input int m);
    logic [0:M-1] r;
    r = '0;
    r[m] = 1'b1;
    return r;
  endfunction
  function automatic logic [0:N-1] ohn(input int n);
    logic [0:N-1] r;
    r = '0;
    r[n] = 1'b1;
    return r;
  endfunction
  function automatic int first_bit(input logic [0:M-1] r);
    for (int m = 0; m < M; m++) if (r[m]) return m;
    return -1;
  endfunction
  function automatic logic [0:N-1][0:M-1] rand_req();
    logic [0:N-1][0:M-1] r;
    for (int n = 0; n < N; n++) begin
      case ($urandom_range(0, 5))
        0: r[n] = '0;
        1: r[n] = M'($urandom);
        default: r[n] = oh($urandom_range(0, M - 1));
      endcase
    end
    return r;
  endfunction
  task automatic apply(input logic [0:N-1][0:M-1] req, input logic [0:M-1] en, input logic rst);
    logic [0:M-1][0:N-1] es;
    logic [0:N-1]        eg;
    logic [0:M-1][7:0]   ex, ax;
    int                  win [M];
    int                  n;
    @(negedge clk);
    i_request = req;
    i_en = en;
    reset = rst;
    for (int i = 0; i < N; i++) pkt[i] = 8'($urandom);
    #1;
    es = '0;
    eg = '0;
    for (int m = 0; m < M; m++) begin
      win[m] = -1;
      ex[m] = 'z;
      ax[m] = 'z;
      if (!rst && en[m]) begin
        for (int k = 0; k < N; k++) begin
          n = (mptr[m] + k) % N;
          if (win[m] < 0 && first_bit(req[n]) == m) begin
            win[m] = n;
            es[m][n] = 1'b1;
            eg[n] = 1'b1;
            ex[m] = pkt[n];
          end
        end
      end
      for (int j = 0; j < N; j++) if (o_sel[m][j]) ax[m] = pkt[j];
    end
    vectors++;
    assert (o_sel === es) else begin
      miscompares++;
      $error("FAIL sel got %b exp %b", o_sel, es);
    end
    assert (o_grant === eg) else begin
      miscompares++;
      $error("FAIL grant got %b exp %b", o_grant, eg);
    end
    assert (ax === ex) else begin
      miscompares++;
      $error("FAIL xbar got %h exp %h", ax, ex);
    end
    for (int m = 0; m < M; m++)
      mptr[m] = rst ? 0 : (win[m] >= 0) ? (win[m] + 1) % N : mptr[m];
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask
  initial begin
    logic [0:N-1][0:M-1] r;
    int                  exp_w [6] = '{0, 2, 4, 0, 2, 4};
    for (int m = 0; m < M; m++) mptr[m] = 0;
    for (int i = 0; i < 2; i++) begin
      apply(rand_req(), M'($urandom), 1'b1);
      chk("rst_sel", 32'(o_sel), 32'd0);
      chk("rst_grant", 32'(o_grant), 32'd0);
    end
    r = '0;
    r[0] = oh(1);
    r[2] = oh(1);
    r[4] = oh(1);
    for (int i = 0; i < 6; i++) begin
      apply(r, '1, 1'b0);
      chk("cont_sel1", 32'(o_sel[1]), 32'(ohn(exp_w[i])));
      chk("cont_grant", 32'(o_grant), 32'(ohn(exp_w[i])));
    end
    r = '0;
    r[3] = oh(0);
    apply(r, '1, 1'b0);
    chk("wrap_prep", 32'(o_grant), 32'(ohn(3)));
    r = '0;
    r[4] = oh(0);
    r[0] = oh(0);
    apply(r, '1, 1'b0);
    chk("wrap_hi", 32'(o_sel[0]), 32'(ohn(4)));
    apply(r, '1, 1'b0);
    chk("wrap_lo", 32'(o_sel[0]), 32'(ohn(0)));
    r = '0;
    r[1] = oh(2);
    for (int i = 0; i < 3; i++) begin
      apply(r, ~oh(2), 1'b0);
      chk("bp_sel2", 32'(o_sel[2]), 32'd0);
      chk("bp_grant", 32'(o_grant), 32'd0);
    end
    apply(r, '1, 1'b0);
    chk("bp_release", 32'(o_grant), 32'(ohn(1)));
    r = '0;
    r[0] = oh(3);
    r[1] = oh(4);
    r[2] = oh(1) | oh(2);
    apply(r, '1, 1'b0);
    chk("par_grant", 32'(o_grant), 32'(ohn(0) | ohn(1) | ohn(2)));
    chk("ill_sel1", 32'(o_sel[1]), 32'(ohn(2)));
    chk("ill_sel2", 32'(o_sel[2]), 32'd0);
    for (int i = 0; i < 400; i++)
      apply(rand_req(), ($urandom_range(0, 3) == 0) ? M'($urandom) : '1, $urandom_range(0, 39) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
